// File: rtl/clk_cfg_seq.sv
// clk_cfg_seq: clock-configuration sequencer.
// Parks the system clock on the 8 MHz source, applies a new clock setup,
// waits for settle or PLL lock, then releases the park. Because the block
// runs on the clock it controls, every wait is counted in 8 MHz cycles.
module clk_cfg_seq #(
  parameter int PARK_CYC   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CYC   = 64,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_pll_en,
  input  logic [1:0] req_pll_trim,
  input  logic       req_sel_pll,
  input  logic       req_sel_xclk,
  input  logic [1:0] req_sel_rosc,
  input  logic [1:0] req_clk_div,
  input  logic       req_park,
  output logic       pll_en,
  output logic       sel_8mhz,
  output logic       sel_pll,
  output logic       sel_xclk,
  output logic [1:0] sel_rosc,
  output logic [1:0] pll_trim,
  output logic [1:0] clk_div,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    PARK,
    WAIT
  } state_t;

  // Counter reload values; each wait of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] PARK_LOAD   = CNT_W'(PARK_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       sh_pll_en;
  logic [1:0] sh_pll_trim;
  logic       sh_sel_pll;
  logic       sh_sel_xclk;
  logic [1:0] sh_sel_rosc;
  logic [1:0] sh_clk_div;
  logic       sh_park;

  logic illegal_req;
  logic relock;

  // Selecting the PLL while it is disabled would leave the system without a clock.
  assign illegal_req = req_sel_pll & ~req_pll_en;

  // The PLL must relock when it is newly enabled or when its trim or reference
  // changes; the ring-oscillator select only matters when it is the reference.
  assign relock = sh_pll_en &
                  (~pll_en |
                   (sh_pll_trim != pll_trim) |
                   (sh_sel_xclk != sel_xclk) |
                   ((sh_sel_rosc != sel_rosc) & ~sh_sel_xclk));

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Sequencer: capture request, park, apply settings, wait, unpark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pll_en      <= 1'b0;
      pll_trim    <= 2'b11;
      sel_8mhz    <= 1'b1;
      sel_pll     <= 1'b0;
      sel_xclk    <= 1'b1;
      sel_rosc    <= 2'b00;
      clk_div     <= 2'b00;
      done        <= 1'b0;
      err         <= 1'b0;
      sh_pll_en   <= 1'b0;
      sh_pll_trim <= 2'b11;
      sh_sel_pll  <= 1'b0;
      sh_sel_xclk <= 1'b1;
      sh_sel_rosc <= 2'b00;
      sh_clk_div  <= 2'b00;
      sh_park     <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            sh_pll_en   <= req_pll_en;
            sh_pll_trim <= req_pll_trim;
            sh_sel_pll  <= req_sel_pll;
            sh_sel_xclk <= req_sel_xclk;
            sh_sel_rosc <= req_sel_rosc;
            sh_clk_div  <= req_clk_div;
            sh_park     <= req_park;
            if (illegal_req) begin
              err <= 1'b1;
            end else begin
              sel_8mhz <= 1'b1;
              cnt      <= PARK_LOAD;
              state    <= PARK;
            end
          end
        end
        PARK: begin
          if (cnt == '0) begin
            pll_en   <= sh_pll_en;
            pll_trim <= sh_pll_trim;
            sel_pll  <= sh_sel_pll;
            sel_xclk <= sh_sel_xclk;
            sel_rosc <= sh_sel_rosc;
            clk_div  <= sh_clk_div;
            cnt      <= relock ? LOCK_LOAD : SETTLE_LOAD;
            state    <= WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            sel_8mhz <= sh_park;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_cfg_seq.sv
// tb_clk_cfg_seq: self-checking bench for clk_cfg_seq.
// The reference model tracks only the applied configuration and park state and
// predicts, per clock edge after a handshake, what every output must show.
module tb_clk_cfg_seq;

  localparam int P = 4;
  localparam int S = 8;
  localparam int L = 64;

  // Config vector layout: {pll_en, pll_trim[1:0], sel_pll, sel_xclk, sel_rosc[1:0], clk_div[1:0]}
  localparam logic [8:0]  RST_CFG = 9'b0_11_0_1_00_00;
  // Observation layout: {config, sel_8mhz, busy, done, err, req_ready}
  localparam logic [13:0] RST_OBS = {RST_CFG, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_pll_en = 1'b0;
  logic [1:0] req_pll_trim = 2'b00;
  logic       req_sel_pll = 1'b0;
  logic       req_sel_xclk = 1'b0;
  logic [1:0] req_sel_rosc = 2'b00;
  logic [1:0] req_clk_div = 2'b00;
  logic       req_park = 1'b0;
  logic       pll_en, sel_8mhz, sel_pll, sel_xclk;
  logic [1:0] sel_rosc, pll_trim, clk_div;
  logic       busy, done, err;

  int checks = 0;
  int passed = 0;

  logic [8:0] cur_cfg  = RST_CFG;
  logic       cur_sel8 = 1'b1;

  clk_cfg_seq #(.PARK_CYC(P), .SETTLE_CYC(S), .LOCK_CYC(L), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pll_en  (req_pll_en),
    .req_pll_trim(req_pll_trim),
    .req_sel_pll (req_sel_pll),
    .req_sel_xclk(req_sel_xclk),
    .req_sel_rosc(req_sel_rosc),
    .req_clk_div (req_clk_div),
    .req_park    (req_park),
    .pll_en      (pll_en),
    .sel_8mhz    (sel_8mhz),
    .sel_pll     (sel_pll),
    .sel_xclk    (sel_xclk),
    .sel_rosc    (sel_rosc),
    .pll_trim    (pll_trim),
    .clk_div     (clk_div),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] out_cfg();
    return {pll_en, pll_trim, sel_pll, sel_xclk, sel_rosc, clk_div};
  endfunction

  function automatic logic [13:0] observe();
    return {out_cfg(), sel_8mhz, busy, done, err, req_ready};
  endfunction

  // Wait length from the lock rules, computed on whole configuration words.
  function automatic int wait_len(input logic [8:0] o, input logic [8:0] n);
    bit lock;
    lock = n[8] && (!o[8] || (o[7:6] != n[7:6]) || (o[4] != n[4]) ||
                    ((o[3:2] != n[3:2]) && !n[4]));
    return lock ? L : S;
  endfunction

  task automatic set_req(input logic [8:0] c, input logic park);
    {req_pll_en, req_pll_trim, req_sel_pll, req_sel_xclk, req_sel_rosc, req_clk_div} = c;
    req_park = park;
  endtask

  // Present one request, then follow it edge by edge against the model.
  // hold keeps req_valid high with the next request; abort_k >= 0 pulses reset
  // after edge E(abort_k).
  task automatic run_request(input string name, input logic [8:0] c, input logic park,
                             input bit hold, input logic [8:0] nc, input logic np,
                             input int abort_k);
    int waits, total;
    logic [13:0] exp_obs;
    logic [8:0]  ecfg, pcfg;
    logic        esel, ebusy, edone;
    set_req(c, park);
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    checks++;
    if (waits != 0) begin
      $display("[TB] FAIL %s handshake: waited %0d edges, required 0", name, waits);
      if (waits >= 200) begin
        req_valid = 1'b0;
        return;
      end
    end else passed++;
    @(posedge clk); #1;
    if (hold) set_req(nc, np);
    else begin
      req_valid = 1'b0;
      set_req(9'($urandom), 1'($urandom));
    end
    if (c[5] && !c[8]) begin
      exp_obs = {cur_cfg, cur_sel8, 1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (observe() !== exp_obs) $display("[TB] FAIL %s err_pulse: got %h, required %h", name, observe(), exp_obs);
      else passed++;
      @(posedge clk); #1;
      exp_obs = {cur_cfg, cur_sel8, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (observe() !== exp_obs) $display("[TB] FAIL %s err_end: got %h, required %h", name, observe(), exp_obs);
      else passed++;
      return;
    end
    total = P + wait_len(cur_cfg, c);
    pcfg  = cur_cfg;
    for (int k = 0; k <= total; k++) begin
      if (k == abort_k) begin
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        cur_cfg  = RST_CFG;
        cur_sel8 = 1'b1;
        checks++;
        if (observe() !== RST_OBS) $display("[TB] FAIL %s async_reset: got %h, required %h", name, observe(), RST_OBS);
        else passed++;
        for (int r = 0; r < 3; r++) begin
          @(posedge clk); #1;
          checks++;
          if (observe() !== RST_OBS) $display("[TB] FAIL %s in_reset cycle %0d: got %h, required %h", name, r, observe(), RST_OBS);
          else passed++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (observe() !== RST_OBS) $display("[TB] FAIL %s after_reset: got %h, required %h", name, observe(), RST_OBS);
        else passed++;
        return;
      end
      ecfg  = (k < P) ? cur_cfg : c;
      esel  = (k < total) ? 1'b1 : park;
      ebusy = (k < total);
      edone = (k == total);
      exp_obs = {ecfg, esel, ebusy, edone, 1'b0, !ebusy};
      checks++;
      if (observe() !== exp_obs) $display("[TB] FAIL %s E%0d: got %h, required %h", name, k, observe(), exp_obs);
      else passed++;
      checks++;
      if (out_cfg() !== pcfg && sel_8mhz !== 1'b1)
        $display("[TB] FAIL %s glitch E%0d: sel_8mhz %b while config changed", name, k, sel_8mhz);
      else passed++;
      pcfg = out_cfg();
      if (k < total) begin
        @(posedge clk); #1;
      end
    end
    cur_cfg  = c;
    cur_sel8 = park;
    if (!hold) begin
      @(posedge clk); #1;
      exp_obs = {c, park, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (observe() !== exp_obs) $display("[TB] FAIL %s post_done: got %h, required %h", name, observe(), exp_obs);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (observe() !== RST_OBS) $display("[TB] FAIL reset_values: got %h, required %h", observe(), RST_OBS);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observe() !== RST_OBS) $display("[TB] FAIL reset_idle cycle %0d: got %h, required %h", i, observe(), RST_OBS);
      else passed++;
    end
  endtask

  task automatic test_lock_path();
    run_request("lock_path", 9'b1_10_1_0_00_01, 1'b0, 1'b0, 9'd0, 1'b0, -1);
  endtask

  task automatic test_settle_path();
    logic [8:0] c;
    c = cur_cfg;
    c[1:0] = 2'b11;
    run_request("settle_path", c, 1'b0, 1'b0, 9'd0, 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_request("illegal", 9'b0_11_1_1_00_00, 1'b0, 1'b0, 9'd0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [8:0] a, b;
    a = {1'b1, cur_cfg[7:6], 1'b1, 1'b1, 2'b01, 2'b10};
    b = 9'b1_01_0_0_10_00;
    run_request("b2b_first", a, 1'b1, 1'b1, b, 1'b0, -1);
    run_request("b2b_second", b, 1'b0, 1'b0, 9'd0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_lock();
    logic [8:0] c;
    c = {1'b1, ~cur_cfg[7:6], 1'b0, 1'b0, 2'b00, 2'b01};
    run_request("reset_mid", c, 1'b0, 1'b0, 9'd0, 1'b0, 30);
    run_request("after_reset", 9'b1_01_1_1_00_10, 1'b0, 1'b0, 9'd0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) begin
      run_request("random", 9'($urandom), 1'($urandom), 1'b0, 9'd0, 1'b0, -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_path();
    test_settle_path();
    test_illegal();
    test_back_to_back();
    test_reset_mid_lock();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/clk_cfg_seq.md
# clk_cfg_seq

Clock-configuration sequencer that drives the control inputs of the reset/clock controller (pll_en, sel_8mhz, sel_pll, sel_xclk, sel_rosc, pll_trim, clk_div). It accepts a target configuration over a valid/ready handshake and applies it glitch-safely:

1. Park the system clock on the 8 MHz source.
2. Apply the new settings.
3. Wait a settle or PLL-lock interval.
4. Unpark.

It runs on the system clock it controls, so while parked it counts 8 MHz cycles.

## Interface
- PARK_CYC, 4: cycles held on 8 MHz before settings are applied (≥1).
- SETTLE_CYC, 8: wait after apply when the PLL needs no relock (≥1).
- LOCK_CYC, 64: wait after apply when the PLL must relock (≥1).
- CNT_W, 8: wait-counter width; must hold max(PARK_CYC, SETTLE_CYC, LOCK_CYC)−1.
- clk  in  1  system clock (controller output)
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  configuration request
- req_ready  out  1  high only in IDLE
- req_pll_en  in  1  target PLL enable
- req_pll_trim  in  2  target PLL trim
- req_sel_pll  in  1  target PLL select
- req_sel_xclk  in  1  target PLL reference (1 = external clock)
- req_sel_rosc  in  2  target ring-oscillator select
- req_clk_div  in  2  target divider (0 = /1, 1 = /2, 2 = /4, 3 = /8)
- req_park  in  1  stay on 8 MHz after the sequence
- pll_en, sel_8mhz, sel_pll, sel_xclk  out  1  controller controls
- sel_rosc, pll_trim, clk_div  out  2  controller controls
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at sequence end
- err  out  1  one-cycle pulse on a rejected request

## Operation
- Reset values:
  - pll_en = 0, pll_trim = 2'b11, sel_8mhz = 1, sel_pll = 0, sel_xclk = 1, sel_rosc = 0, clk_div = 0.
  - busy = 0, done = 0, err = 0, state IDLE, counter 0.
  - After reset the outputs stay parked until the first request.
- States: IDLE → PARK → WAIT → IDLE. Outputs are registered.
- IDLE:
  - req_ready = 1.
  - Handshake occurs on an edge where req_valid & req_ready.
  - All req_* fields are captured into shadow registers at that edge; later changes on req_* are ignored.
- Illegal request (req_sel_pll = 1 & req_pll_en = 0):
  - err = 1 for the next cycle.
  - State stays IDLE; no control output changes.
- Legal request:
  - sel_8mhz ← 1, counter ← PARK_CYC−1, state ← PARK.
- PARK:
  - Counter decrements each cycle.
  - At the edge where counter = 0: pll_en, pll_trim, sel_pll, sel_xclk, sel_rosc, clk_div all update together from the shadow registers. sel_8mhz stays 1.
  - Counter ← W−1, state ← WAIT.
  - W = LOCK_CYC if the new pll_en = 1 and any of the following holds; otherwise W = SETTLE_CYC:
    - old pll_en = 0;
    - pll_trim changed;
    - sel_xclk changed;
    - sel_rosc changed while new sel_xclk = 0.
- WAIT:
  - At the edge where counter = 0: sel_8mhz ← shadow req_park, done ← 1 for one cycle, state ← IDLE.
- Requests presented while busy stall (req_ready = 0) and are not lost.
- A request equal to the current configuration still runs the full sequence.
- The counter never wraps; it is loaded only at state entry.

## Timing
- E0 = handshake edge.
- sel_8mhz is high from E0 (it is already high if previously parked).
- Config outputs update at edge E(PARK_CYC).
- sel_8mhz is released and done pulses at edge E(PARK_CYC+W).
- req_ready returns high at the same edge as done, so back-to-back requests are accepted no earlier than one edge after done.
- With defaults: settle path done at E12, lock path done at E68.
- err pulses at E0+1 cycle (high for the cycle after E0).
- rst_n assertion at any point, including mid-PARK or mid-WAIT:
  - All outputs return to reset values immediately (asynchronously).
  - No done or err pulse.
  - The shadow request is discarded.
- sel_8mhz is never low during any cycle in which another control output changes.

## Test plan
- Reset then idle 20 cycles → outputs at reset values, req_ready = 1, busy = 0, done never asserts.
- Request pll_en = 1, trim = 2, sel_pll = 1, sel_xclk = 0, div = 1, park = 0 → sel_8mhz = 1 from E0, config changes at E4, sel_8mhz = 0 and done pulse at E68, busy high E0..E67.
- From the previous configuration, request only clk_div = 3 (PLL unchanged) → SETTLE path, done at E12, pll_en stays 1.
- Request sel_pll = 1 with pll_en = 0 → err pulse one cycle after the handshake, no output change, busy = 0.
- Hold req_valid high continuously with two different configurations → the second is accepted only after done; final outputs equal the second configuration.
- Assert rst_n low at E30 of a lock sequence → outputs immediately at reset values, no done; a new request after release completes normally.
